// File: rtl/kim_bus_arbiter.sv
// KIM-1 system bus arbiter: shares AB/DO/WE between the 6502 core and a host
// debug/loader port, stalling the CPU through RDY while the host owns the bus.
module kim_bus_arbiter #(
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned CPU_HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        host_owns,
  output logic [15:0] bus_ab,
  output logic [7:0]  bus_do,
  output logic        bus_we,
  input  logic [7:0]  bus_di
);

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [3:0] HOLDOFF_LD  = 4'(CPU_HOLDOFF);

  typedef enum logic [2:0] {
    ST_CPU,
    ST_H_ADDR,
    ST_H_DATA,
    ST_H_GAP,
    ST_RELEASE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic [3:0] holdoff_q, holdoff_d;
  logic [7:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_CPU;
      burst_q   <= 8'd0;
      holdoff_q <= 4'd0;
      rdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      holdoff_q <= holdoff_d;
      rdata_q   <= rdata_d;
    end
  end

  // While reset is low the outputs look like an idle CPU state, so an access
  // caught in flight never produces an ack or a host bus cycle.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    holdoff_d  = holdoff_q;
    rdata_d    = rdata_q;
    cpu_rdy    = 1'b1;
    host_ack   = 1'b0;
    host_owns  = 1'b0;
    host_rdata = rdata_q;
    bus_ab     = cpu_ab;
    bus_do     = cpu_do;
    bus_we     = cpu_we;

    if (reset) begin
      case (state_q)
        ST_CPU: begin
          if (holdoff_q != 4'd0) holdoff_d = holdoff_q - 4'd1;
          // CPU writes are never cut short; the stalled read is re-issued later.
          if (host_req && !cpu_we && (holdoff_q == 4'd0)) begin
            cpu_rdy = 1'b0;
            burst_d = 8'd0;
            state_d = ST_H_ADDR;
          end
        end
        ST_H_ADDR: begin
          bus_ab    = host_addr;
          bus_do    = host_wdata;
          bus_we    = host_we;
          cpu_rdy   = 1'b0;
          host_owns = 1'b1;
          state_d   = ST_H_DATA;
        end
        ST_H_DATA: begin
          bus_ab    = host_addr;
          bus_do    = host_wdata;
          bus_we    = 1'b0;
          cpu_rdy   = 1'b0;
          host_owns = 1'b1;
          host_ack  = 1'b1;
          if (!host_we) begin
            rdata_d    = bus_di;
            host_rdata = bus_di;
          end
          burst_d = burst_q + 8'd1;
          state_d = (burst_d == BURST_LIMIT) ? ST_RELEASE : ST_H_GAP;
        end
        ST_H_GAP: begin
          bus_ab    = host_addr;
          bus_do    = host_wdata;
          bus_we    = 1'b0;
          cpu_rdy   = 1'b0;
          host_owns = 1'b1;
          state_d   = host_req ? ST_H_ADDR : ST_RELEASE;
        end
        ST_RELEASE: begin
          bus_we    = 1'b0;
          cpu_rdy   = 1'b0;
          holdoff_d = HOLDOFF_LD;
          state_d   = ST_CPU;
        end
        default: state_d = ST_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_kim_bus_arbiter.sv
// Directed plus randomized bench for kim_bus_arbiter, checked every cycle
// against a transaction-position reference model and a shadow memory.
module tb_kim_bus_arbiter;

  localparam int MB = 4;
  localparam int HO = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        cpu_rdy;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_owns;
  logic [15:0] bus_ab;
  logic [7:0]  bus_do;
  logic        bus_we;
  logic [7:0]  bus_di;

  kim_bus_arbiter #(.MAX_BURST(MB), .CPU_HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_owns(host_owns), .bus_ab(bus_ab), .bus_do(bus_do), .bus_we(bus_we),
    .bus_di(bus_di)
  );

  always #5 clk = ~clk;

  // Power-up memory contents: stored values are XORed with this pattern.
  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Registered memory on the bus (read data valid the cycle after the address).
  bit [7:0] env_mem [0:65535];
  logic [7:0] di_r;
  always @(posedge clk) begin
    if (bus_we === 1'b1) env_mem[bus_ab] <= bus_do ^ f(bus_ab);
    di_r <= env_mem[bus_ab] ^ f(bus_ab);
  end
  assign bus_di = di_r;

  // Reference model: mode 0 = CPU owns, 1 = host owns (m_pos counts cycles
  // since the grant, three per access), 2 = handing the bus back.
  bit [7:0] sh [0:65535];
  int   m_mode, m_pos, m_nacc, m_hold;
  logic [7:0] m_held;
  bit   m_was_rel;

  int n_vec = 0;
  int n_mis = 0;
  logic o_ack, o_rdy, o_owns, o_we;
  logic [7:0]  o_rdata;
  logic [15:0] o_ab;
  int n_we_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [15:0] e_ab;
    logic [7:0]  e_do, e_rdata;
    logic        e_we, e_rdy, e_ack, e_owns, pre, host_phase;
    int k;
    @(negedge clk);
    pre = 1'b0; k = 0; host_phase = 1'b0;
    e_ab = cpu_ab; e_do = cpu_do; e_we = cpu_we;
    e_rdy = 1'b1; e_ack = 1'b0; e_owns = 1'b0; e_rdata = m_held;
    if (reset && m_mode == 1) begin
      host_phase = 1'b1;
      k = (m_pos - 1) % 3;
      e_ab = host_addr; e_do = host_wdata;
      e_we = (k == 0) ? host_we : 1'b0;
      e_rdy = 1'b0; e_owns = 1'b1; e_ack = (k == 1);
      if (k == 1 && !host_we) e_rdata = sh[host_addr] ^ f(host_addr);
    end else if (reset && m_mode == 2) begin
      e_we = 1'b0; e_rdy = 1'b0;
    end else if (reset) begin
      pre = host_req && !cpu_we && (m_hold == 0);
      e_rdy = !pre;
    end
    chk("cpu_rdy", 16'(cpu_rdy), 16'(e_rdy));
    chk("host_ack", 16'(host_ack), 16'(e_ack));
    chk("host_owns", 16'(host_owns), 16'(e_owns));
    chk("host_rdata", 16'(host_rdata), 16'(e_rdata));
    chk("bus_ab", bus_ab, e_ab);
    chk("bus_we", 16'(bus_we), 16'(e_we));
    if (!(host_phase && k != 0)) chk("bus_do", 16'(bus_do), 16'(e_do));
    if (reset && m_mode == 0 && m_was_rel && !cpu_we)
      chk("cpu_resume_di", 16'(bus_di), 16'(sh[cpu_ab] ^ f(cpu_ab)));
    o_ack = host_ack; o_rdy = cpu_rdy; o_owns = host_owns; o_we = bus_we;
    o_rdata = host_rdata; o_ab = bus_ab;
    if (bus_we === 1'b1) n_we_cnt++;
    if (e_we) sh[e_ab] = e_do ^ f(e_ab);
    m_was_rel = 1'b0;
    if (!reset) begin
      m_mode = 0; m_hold = 0; m_held = 8'h00; m_pos = 0; m_nacc = 0;
    end else if (m_mode == 0) begin
      if (m_hold > 0) m_hold--;
      if (pre) begin m_mode = 1; m_pos = 1; m_nacc = 0; end
    end else if (m_mode == 1) begin
      if (k == 0) m_pos++;
      else if (k == 1) begin
        m_nacc++;
        m_held = e_rdata;
        if (m_nacc == MB) m_mode = 2; else m_pos++;
      end else begin
        if (host_req) m_pos++; else m_mode = 2;
      end
    end else begin
      m_mode = 0; m_hold = HO; m_was_rel = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_ack && n < budget);
    chk("ack_seen", 16'(o_ack), 16'd1);
  endtask

  logic ack_a [16];
  logic rdy_a [16];
  logic we_a  [16];
  logic [15:0] ab_a [16];

  initial begin
    int n, acks;
    m_mode = 0; m_pos = 0; m_nacc = 0; m_hold = 0; m_held = 8'h00; m_was_rel = 1'b0;
    n_we_cnt = 0;

    // Reset held with a pending host request
    reset = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0200;
    host_wdata = 8'h5A; cpu_ab = 16'h0300; cpu_do = 8'h00; cpu_we = 1'b0;
    repeat (3) begin
      step();
      chk("rst_rdy", 16'(o_rdy), 16'd1);
      chk("rst_ack", 16'(o_ack), 16'd0);
      chk("rst_ab", o_ab, 16'h0300);
    end

    // CPU writing: no preemption
    reset = 1'b1; cpu_we = 1'b1; cpu_ab = 16'h0210; cpu_do = 8'h11;
    repeat (2) begin
      step();
      chk("wp_rdy", 16'(o_rdy), 16'd1);
      chk("wp_owns", 16'(o_owns), 16'd0);
    end

    // Host write 0x5A -> 0x0200
    cpu_we = 1'b0; cpu_ab = 16'h0300;
    n_we_cnt = 0;
    wait_ack(10, n);
    chk("wr_latency", 16'(n), 16'd3);
    chk("wr_we_cycles", 16'(n_we_cnt), 16'd1);
    host_req = 1'b0;
    repeat (4) step();

    // Host read back
    host_req = 1'b1; host_we = 1'b0;
    wait_ack(10, n);
    chk("rd_latency", 16'(n), 16'd3);
    chk("rd_data", 16'(o_rdata), 16'h005A);
    host_req = 1'b0;
    repeat (4) step();

    // Burst limit with host_req held high
    host_req = 1'b1; host_addr = 16'h0201;
    for (int i = 0; i < 16; i++) begin
      step();
      ack_a[i] = o_ack; rdy_a[i] = o_rdy; we_a[i] = o_we; ab_a[i] = o_ab;
    end
    acks = 0;
    for (int i = 0; i < 13; i++) if (ack_a[i]) acks++;
    chk("burst_acks", 16'(acks), 16'(MB));
    chk("burst_rel_ab", ab_a[12], cpu_ab);
    chk("burst_rel_we", 16'(we_a[12]), 16'd0);
    chk("holdoff_rdy0", 16'(rdy_a[13]), 16'd1);
    chk("holdoff_rdy1", 16'(rdy_a[14]), 16'd1);
    chk("regrant", 16'(rdy_a[15]), 16'd0);

    // Request dropped mid-access still completes
    host_req = 1'b0;
    step();
    step();
    chk("drop_ack", 16'(o_ack), 16'd1);
    repeat (4) step();

    // ROM read while the CPU is stalled at its own address
    host_req = 1'b1; host_addr = 16'h1C00; cpu_ab = 16'h0305;
    wait_ack(10, n);
    chk("rom_data", 16'(o_rdata), 16'h0020);
    host_req = 1'b0;
    repeat (4) step();
    chk("rdata_held", 16'(o_rdata), 16'h0020);

    // Reset during H_DATA
    host_req = 1'b1; host_addr = 16'h0202;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rstmid_ack", 16'(o_ack), 16'd0);
    reset = 1'b1; host_req = 1'b0;
    step();
    chk("rstmid_rdy", 16'(o_rdy), 16'd1);
    chk("rstmid_owns", 16'(o_owns), 16'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) != 0);
      if (!reset) host_req = 1'b0;
      else if (o_ack || !host_req) begin
        if ((o_ack && $urandom_range(0, 1) == 0) || (!o_ack && $urandom_range(0, 3) != 0))
          host_req = 1'b0;
        else begin
          host_req = 1'b1;
          host_we = $urandom_range(0, 1) == 1;
          host_addr = {12'h020, 4'($urandom_range(0, 15))};
          host_wdata = 8'($urandom);
        end
      end
      if (o_rdy) begin
        cpu_ab = {12'h020, 4'($urandom_range(0, 15))};
        cpu_do = 8'($urandom);
        cpu_we = $urandom_range(0, 3) == 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/kim_bus_arbiter.md
Name: kim_bus_arbiter

Overview:
- Shares the KIM-1 system bus (address, write data, write enable) between the 6502 core and a host debug/loader port.
- A host port (serial monitor, JTAG bridge) can read or write RAM, ROM and 6530 space while the CPU is stalled through RDY.
- Sits between mcs6502 and the memory/6530 decode logic.
- The arbiter replaces the constant RDY=1 tie-off and owns the AB/DO/WE net that feeds the decoders.

Parameters:
- MAX_BURST, 16: maximum host accesses per grant before the bus is forcibly returned to the CPU. Range 1..255.
- CPU_HOLDOFF, 2: minimum cycles the CPU keeps the bus, with RDY=1, after a release before the next grant. Range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- cpu_ab  in  16  CPU address
- cpu_do  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_rdy  out  1  RDY to CPU (combinational)
- host_req  in  1  host access request (level)
- host_we  in  1  host write (1) / read (0)
- host_addr  in  16  host address
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  read data; valid while host_ack=1, held until the next ack
- host_owns  out  1  1 while the host owns the bus
- bus_ab  out  16  to decoder/memories
- bus_do  out  8  write data to memories
- bus_we  out  1  write enable to memories
- bus_di  in  8  merged read data; memories are registered, so data is valid the cycle after the address

Behaviour:
- One clock domain. All state updates on posedge clk.
- reset=0 at an edge forces the following:
  - state=CPU, burst count=0, holdoff count=0
  - host_ack=0, host_rdata=0, host_owns=0
  - an access in flight is abandoned; no ack is produced
- Outputs in CPU state during reset: bus mirrors cpu_*, cpu_rdy=1.
- States:
  - CPU: bus_ab/bus_do/bus_we = cpu_*.
    - cpu_rdy=1, unless preempting this cycle.
    - Holdoff counter decrements to 0.
    - Preempt condition: host_req=1 AND cpu_we=0 AND holdoff=0. CPU writes are never preempted.
    - On preempt: cpu_rdy=0 combinationally this cycle, bus still carries the CPU read, next state=H_ADDR, burst count=0.
  - H_ADDR: bus_ab=host_addr, bus_we=host_we, bus_do=host_wdata.
    - cpu_rdy=0, host_owns=1.
    - Next state=H_DATA.
  - H_DATA: bus_ab=host_addr, bus_we=0.
    - Capture bus_di into host_rdata on reads; host_rdata is unchanged on writes.
    - host_ack=1, burst count+1.
    - Next state=RELEASE if the count reaches MAX_BURST, else H_GAP.
  - H_GAP: bus_ab=host_addr, bus_we=0, cpu_rdy=0, host_owns=1.
    - If host_req=1, next state=H_ADDR (a new transaction); else next state=RELEASE.
  - RELEASE: bus = cpu_* with bus_we forced 0. This re-issues the stalled CPU read.
    - cpu_rdy=0, host_owns=0.
    - Next state=CPU, holdoff loaded with CPU_HOLDOFF.
    - On the first CPU cycle, bus_di holds the CPU's data and RDY=1.
- Handshake:
  - The host holds host_req/addr/we/wdata stable from request until its ack.
  - host_req sampled high in the cycle after an ack (H_GAP) is a new transfer.
  - Throughput: one access per 3 cycles within a burst.
- Latency: request to ack is 3 cycles when the CPU is idle-readable (preempt, H_ADDR, H_DATA).
- The CPU holds cpu_ab stable while cpu_rdy=0.
- The preempt-cycle read and the RELEASE read both hit the same CPU address. Double reads of side-effecting 6530 registers are accepted behaviour.
- host_req dropped mid-access (in H_ADDR or H_DATA): the access still completes and acks. The arbiter then releases from H_GAP.
- If host_req stays high across MAX_BURST accesses: release, CPU runs for at least CPU_HOLDOFF cycles, then a new grant. No starvation of either side.
- No bus_we pulse to memory except in H_ADDR (host) and CPU state (cpu_we).

Test Plan:
- Reset: hold reset=0 for 3 cycles with host_req=1 → cpu_rdy=1, host_ack=0, host_owns=0, bus_ab=cpu_ab. After release, the first grant occurs only when cpu_we=0.
- Host write then read: write 0x5A to 0x0200, then read 0x0200 while the CPU loops on reads → bus_we high for exactly 1 cycle with bus_ab=0x0200, bus_do=0x5A. The read returns host_rdata=0x5A on the second ack; each ack comes 3 cycles after its request.
- Write protection: host_req rises while cpu_we=1 for 2 cycles → no preempt, cpu_rdy stays 1. The grant happens in the first cycle with cpu_we=0.
- Burst limit: MAX_BURST=4, CPU_HOLDOFF=2, host_req held high → exactly 4 acks. Then RELEASE with bus_ab=cpu_ab and bus_we=0, then 2 cycles with cpu_rdy=1, then a re-grant.
- ROM read: host reads 0x1C00 → host_rdata equals ROM2K[0x400]. The CPU resumes and its stalled read at its own address returns correct data, with no instruction skipped.
- Reset mid-access: reset=0 during H_DATA → no host_ack, state CPU, cpu_rdy=1 in the cycle after reset.
